// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract with valid/ready flow control and RNE rounding.
// Define FPU_ADDSUB_FTZ_EN to flush subnormal operands and results to signed zero.
module fpu_addsub_pipe #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sub,
  input  logic [EXPW+FRACW:0] in_a,
  input  logic [EXPW+FRACW:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXPW+FRACW:0] out_result,
  output logic [3:0]          out_cc,
  output logic [3:0]          out_flags
);

  localparam int W  = 1 + EXPW + FRACW;
  localparam int EW = FRACW + 4;   // hidden + fraction + guard/round/sticky
  localparam int SW = EW + 1;      // plus carry-out
  localparam int XW = EXPW + 2;    // exponent with headroom for carry and round-up

  localparam logic [EXPW-1:0] EMAX  = '1;
  localparam logic [XW-1:0]   ONE_X = XW'(1);
  localparam logic [W-1:0]    QNAN  = {1'b0, EMAX, 1'b1, {(FRACW-1){1'b0}}};

  typedef struct packed {
    logic          special;
    logic [W-1:0]  spec_res;
    logic          spec_nv;
    logic          sign;
    logic          eff_sub;
    logic [XW-1:0] exp;
    logic [EW-1:0] sig_l;
    logic [EW-1:0] sig_s;
  } s1_t;

  typedef struct packed {
    logic          special;
    logic [W-1:0]  spec_res;
    logic          spec_nv;
    logic          sign;
    logic [XW-1:0] exp;
    logic [SW-1:0] sum;
  } s2_t;

  // Handshake: each stage may load when empty or when its successor moves on.
  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  assign en3       = !v3_q || out_ready;
  assign en2       = !v2_q || en3;
  assign en1       = !v1_q || en2;
  assign in_ready  = en1;
  assign out_valid = v3_q;

  // Stage 1: classify, sort by magnitude, align the smaller significand.
  s1_t              s1_d, s1_q;
  logic             a_s, b_s, l_s, s_s;
  logic [EXPW-1:0]  a_e, b_e, l_e, s_e, l_ee, s_ee, diff;
  logic [FRACW-1:0] a_f, b_f, l_f, s_f;
  logic             a_nan, b_nan, a_inf, b_inf, swap;
  logic [EW-1:0]    l_sig, s_ext, s_mask;

  // NOTE: every variable driven here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    a_s = in_a[W-1];
    a_e = in_a[W-2:FRACW];
    a_f = in_a[FRACW-1:0];
    b_s = in_b[W-1] ^ in_sub;
    b_e = in_b[W-2:FRACW];
    b_f = in_b[FRACW-1:0];
`ifdef FPU_ADDSUB_FTZ_EN
    if (a_e == '0) a_f = '0;
    if (b_e == '0) b_f = '0;
`endif
    a_nan = (a_e == EMAX) && (a_f != '0);
    b_nan = (b_e == EMAX) && (b_f != '0);
    a_inf = (a_e == EMAX) && (a_f == '0);
    b_inf = (b_e == EMAX) && (b_f == '0);

    swap = {b_e, b_f} > {a_e, a_f};
    l_s  = swap ? b_s : a_s;
    l_e  = swap ? b_e : a_e;
    l_f  = swap ? b_f : a_f;
    s_s  = swap ? a_s : b_s;
    s_e  = swap ? a_e : b_e;
    s_f  = swap ? a_f : b_f;

    l_ee  = (l_e == '0) ? EXPW'(1) : l_e;
    s_ee  = (s_e == '0) ? EXPW'(1) : s_e;
    diff  = l_ee - s_ee;
    l_sig = {l_e != '0, l_f, 3'b000};
    s_ext = {s_e != '0, s_f, 3'b000};
    // Shifts past the path width leave nothing but the sticky OR of the whole significand.
    s_mask = ~({EW{1'b1}} << diff);

    s1_d         = '0;
    s1_d.sign    = l_s;
    s1_d.eff_sub = l_s ^ s_s;
    s1_d.exp     = XW'(l_ee);
    s1_d.sig_l   = l_sig;
    s1_d.sig_s   = (s_ext >> diff) | {{(EW-1){1'b0}}, |(s_ext & s_mask)};

    if (a_nan || b_nan) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = QNAN;
    end else if (a_inf && b_inf && (a_s != b_s)) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = QNAN;
      s1_d.spec_nv  = 1'b1;
    end else if (a_inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = {a_s, EMAX, {FRACW{1'b0}}};
    end else if (b_inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = {b_s, EMAX, {FRACW{1'b0}}};
    end
  end

  // Stage 2: magnitude add or subtract; sorting guarantees a non-negative difference.
  s2_t s2_d, s2_q;

  always_comb begin
    s2_d          = '0;
    s2_d.special  = s1_q.special;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.spec_nv  = s1_q.spec_nv;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                                 : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
    s2_d.sign     = (s1_q.eff_sub && (s2_d.sum == '0)) ? 1'b0 : s1_q.sign;
  end

  // Stage 3: normalize, round to nearest even, detect overflow/underflow.
  logic [XW-1:0]    lzc, lim, nsh, exp_n, exp_r;
  logic [EW-1:0]    norm;
  logic [FRACW+1:0] mant_r;
  logic [FRACW-1:0] frac_r;
  logic             g, r, st, nx, of, uf, tiny;
  logic [W-1:0]     res_d, res_q;
  logic [3:0]       flags_d, flags_q, cc_d, cc_q;

  always_comb begin
    lzc = XW'(EW);
    for (int i = 0; i < EW; i++) begin
      if (s2_q.sum[i]) lzc = XW'(EW - 1 - i);
    end

    lim = '0;
    nsh = '0;
    if (s2_q.sum[SW-1]) begin
      norm  = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
      exp_n = s2_q.exp + ONE_X;
    end else begin
      // Never normalize below the minimum exponent; what remains is a subnormal.
      lim   = s2_q.exp - ONE_X;
      nsh   = (lzc < lim) ? lzc : lim;
      norm  = s2_q.sum[EW-1:0] << nsh;
      exp_n = s2_q.exp - nsh;
    end

    g      = norm[2];
    r      = norm[1];
    st     = norm[0];
    mant_r = {1'b0, norm[EW-1:3]} + {{(FRACW+1){1'b0}}, g & (r | st | norm[3])};
    if (mant_r[FRACW+1]) begin
      exp_r  = exp_n + ONE_X;
      frac_r = mant_r[FRACW:1];
    end else begin
      exp_r  = mant_r[FRACW] ? exp_n : '0;
      frac_r = mant_r[FRACW-1:0];
    end

    nx    = g | r | st;
    of    = exp_r >= {2'b00, EMAX};
    tiny  = (exp_r == '0);
    uf    = tiny & nx;
    res_d = {s2_q.sign, exp_r[EXPW-1:0], frac_r};
    if (of) begin
      res_d = {s2_q.sign, EMAX, {FRACW{1'b0}}};
      nx    = 1'b1;
      uf    = 1'b0;
    end
`ifdef FPU_ADDSUB_FTZ_EN
    else if (tiny && (frac_r != '0)) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
      nx    = 1'b1;
      uf    = 1'b1;
    end
`endif
    flags_d = {1'b0, of, uf, nx};

    if (s2_q.special) begin
      res_d   = s2_q.spec_res;
      flags_d = {s2_q.spec_nv, 3'b000};
    end
    cc_d = {res_d[W-2:0] == '0, 1'b0, res_d[W-1], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignment so all stages sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      cc_q    <= '0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (en3 && v2_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
        cc_q    <= cc_d;
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clock) begin
    if (en1 && in_valid) s1_q <= s1_d;
    if (en2 && v1_q)     s2_q <= s2_d;
  end

  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign out_cc     = cc_q;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Scoreboard bench for fpu_addsub_pipe (fp16): directed vectors, stall streaming, mid-flight reset.
module tb_fpu_addsub_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_cc, out_flags;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;
    logic [3:0]  cc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

`ifdef FPU_ADDSUB_FTZ_EN
  localparam logic [15:0] SUBN_RES  = 16'h0000;
  localparam logic [3:0]  SUBN_CC   = 4'b1000;
  localparam logic [3:0]  STKY_FL   = 4'b0000;
  localparam logic [15:0] BORROW_RES = 16'h0400;
`else
  localparam logic [15:0] SUBN_RES  = 16'h0002;
  localparam logic [3:0]  SUBN_CC   = 4'b0000;
  localparam logic [3:0]  STKY_FL   = 4'b0001;
  localparam logic [15:0] BORROW_RES = 16'h03FF;
`endif

  always #5 clock = ~clock;

  fpu_addsub_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sub     (in_sub),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cc     (out_cc),
    .out_flags  (out_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT hands over a result.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_result);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(out_result), 32'(mon_e.res));
        check("flags",  32'(out_flags),  32'(mon_e.flags));
        check("cc",     32'(out_cc),     32'(mon_e.cc));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [15:0] res, input logic [3:0] fl, input logic [3:0] cc);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stuck low for a=%h b=%h", a, b);
    end else begin
      e.res   = res;
      e.flags = fl;
      e.cc    = cc;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [15:0] held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_flags",  32'(out_flags),  32'd0);
    check("rst_cc",     32'(out_cc),     32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Directed vectors.
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 4'b0000);
    issue(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000, 4'b1000);
    issue(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000, 4'b1010);
    issue(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 4'b0000);
    issue(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000, 4'b0000);
    issue(16'h0001, 16'h0001, 1'b0, SUBN_RES, 4'b0000, SUBN_CC);
    issue(16'h3C00, 16'h0001, 1'b0, 16'h3C00, STKY_FL, 4'b0000);
    issue(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001, 4'b0000);
    issue(16'h3C00, 16'h1200, 1'b0, 16'h3C01, 4'b0001, 4'b0000);
    issue(16'h3C00, 16'h7C00, 1'b0, 16'h7C00, 4'b0000, 4'b0000);
    issue(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0000, 4'b0000);
    issue(16'h0400, 16'h0001, 1'b1, BORROW_RES, 4'b0000, 4'b0000);
    drain();

    // Streaming with a 4-cycle output stall once the pipeline is full.
    @(posedge clock);
    #1;
    fork
      begin
        issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 4'b0000);
        issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000, 4'b0000);
        issue(16'h4200, 16'h3C00, 1'b1, 16'h4000, 4'b0000, 4'b0000);
        issue(16'h4400, 16'h4400, 1'b0, 16'h4800, 4'b0000, 4'b0000);
        issue(16'h3800, 16'h3800, 1'b0, 16'h3C00, 4'b0000, 4'b0000);
        issue(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0000, 4'b0010);
        issue(16'hC000, 16'hC000, 1'b0, 16'hC400, 4'b0000, 4'b0010);
        issue(16'h3C00, 16'hBC00, 1'b0, 16'h0000, 4'b0000, 4'b1000);
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        held      = '0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          if (k == 0) held = out_result;
          check("stall_in_ready",  32'(in_ready),  32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          if (k != 0) check("stall_hold", 32'(out_result), 32'(held));
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: they must vanish.
    out_ready = 1'b0;
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 4'b0000);
    issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000, 4'b0000);
    issue(16'h4400, 16'h4400, 1'b0, 16'h4800, 4'b0000, 4'b0000);
    check("full_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    sb.delete();
    #1;
    check("midrst_valid",  32'(out_valid),  32'd0);
    check("midrst_result", 32'(out_result), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // First op after reset: acceptance edge counts as cycle 1, result visible after cycle 3.
    issue(16'h3800, 16'h3800, 1'b0, 16'h3C00, 4'b0000, 4'b0000);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd3);
    drain();

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
